// File: rtl/ialu_rvm_pkg.sv
// Purpose: shared definitions for the IALU RVM multiply/divide responder:
//          command encodings, FSM state type and command-class helpers.
package ialu_rvm_pkg;

   localparam int unsigned CMD_W = 8;

   typedef logic [CMD_W-1:0] cmd_t;

   localparam cmd_t CMD_MUL    = cmd_t'(1);
   localparam cmd_t CMD_MULH   = cmd_t'(2);
   localparam cmd_t CMD_MULHSU = cmd_t'(3);
   localparam cmd_t CMD_MULHU  = cmd_t'(4);
   localparam cmd_t CMD_DIV    = cmd_t'(5);
   localparam cmd_t CMD_DIVU   = cmd_t'(6);
   localparam cmd_t CMD_REM    = cmd_t'(7);
   localparam cmd_t CMD_REMU   = cmd_t'(8);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_mul(input cmd_t c);
      return (c == CMD_MUL) || (c == CMD_MULH) || (c == CMD_MULHSU) || (c == CMD_MULHU);
   endfunction

   function automatic logic is_div(input cmd_t c);
      return (c == CMD_DIV) || (c == CMD_DIVU) || (c == CMD_REM) || (c == CMD_REMU);
   endfunction

   function automatic logic is_rem(input cmd_t c);
      return (c == CMD_REM) || (c == CMD_REMU);
   endfunction

   function automatic logic is_signed_op1(input cmd_t c);
      return (c == CMD_MUL) || (c == CMD_MULH) || (c == CMD_MULHSU) ||
             (c == CMD_DIV) || (c == CMD_REM);
   endfunction

   function automatic logic is_signed_op2(input cmd_t c);
      return (c == CMD_MUL) || (c == CMD_MULH) || (c == CMD_DIV) || (c == CMD_REM);
   endfunction

endpackage

// File: rtl/ialu_rvm_muldiv_iter.sv
// Purpose: one-bit-per-cycle unsigned multiply / restoring-divide datapath.
//   acc holds {hi, lo}: multiply -> {partial product, remaining multiplier},
//   divide -> {partial remainder, quotient bits shifted in}.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   load_i           initialise acc={0,op1}, operand b=op2, counter=XLEN-1
//   step_i           perform one iteration and decrement the counter
//   mul_i            1: shift-add multiply, 0: shift-subtract divide
//   op1_i, op2_i     unsigned magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc_o            accumulator (product, or {remainder, quotient})
//   cnt_o            iteration counter
module ialu_rvm_muldiv_iter
   import ialu_rvm_pkg::*;
#(
   parameter int unsigned XLEN = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     load_i,
   input  logic                     step_i,
   input  logic                     mul_i,
   input  logic [XLEN-1:0]          op1_i,
   input  logic [XLEN-1:0]          op2_i,
   output logic [2*XLEN-1:0]        acc_o,
   output logic [$clog2(XLEN)-1:0]  cnt_o
);

   localparam int unsigned PW    = 2 * XLEN;
   localparam int unsigned SW    = XLEN + 2;
   localparam int unsigned CNT_W = $clog2(XLEN);

   logic [PW-1:0]    acc_q, acc_d;
   logic [XLEN-1:0]  b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  hi_c, lo_c;
   logic [XLEN:0]    a_c, bop_c;
   logic [SW-1:0]    sum_c;
   logic             ge_c;
   logic [PW-1:0]    acc_step_c;

   // Shared adder: multiply adds b when the current multiplier bit is set,
   // divide subtracts b via a + ~b + 1; the carry-out then means a >= b.
   always_comb begin
      hi_c  = acc_q[PW-1:XLEN];
      lo_c  = acc_q[XLEN-1:0];
      a_c   = mul_i ? {1'b0, hi_c} : {hi_c, lo_c[XLEN-1]};
      bop_c = mul_i ? (lo_c[0] ? {1'b0, b_q} : '0) : ~{1'b0, b_q};
      sum_c = {1'b0, a_c} + {1'b0, bop_c} + SW'(!mul_i);
      ge_c  = sum_c[SW-1];
      if (mul_i) begin
         acc_step_c = {sum_c[XLEN:0], lo_c[XLEN-1:1]};
      end else begin
         // Remainder stays below the divisor, so dropping the top bit is safe.
         acc_step_c = {(ge_c ? sum_c[XLEN-1:0] : a_c[XLEN-1:0]), lo_c[XLEN-2:0], ge_c};
      end
   end

   // Next-state for accumulator, operand and counter.
   always_comb begin
      acc_d = acc_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      if (load_i) begin
         acc_d = {XLEN'(0), op1_i};
         b_d   = op2_i;
         cnt_d = CNT_W'(XLEN - 1);
      end else if (step_i) begin
         acc_d = acc_step_c;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_o = acc_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/ialu_rvm_muldiv.sv
// Purpose: IALU RVM responder computing MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   iteratively, with a one-cycle result-ready pulse.
// Ports:
//   clk_i, rst_n_i         clock, async active-low reset
//   ialu_rvm_cmd_vd_i      command valid (level, held until result ready)
//   ialu_cmd_i             operation code
//   ialu_main_op1_i/op2_i  operands
//   ialu_rvm_res_rdy_o     one-cycle result-valid pulse
//   ialu_main_res_o        result, zero outside the pulse
//   busy_o                 high while calculating or presenting the result
module ialu_rvm_muldiv
   import ialu_rvm_pkg::*;
#(
   parameter int unsigned SCR1_XLEN           = 8,
   parameter int unsigned SCR1_IALU_CMD_WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           ialu_rvm_cmd_vd_i,
   input  logic [SCR1_IALU_CMD_WIDTH-1:0] ialu_cmd_i,
   input  logic [SCR1_XLEN-1:0]           ialu_main_op1_i,
   input  logic [SCR1_XLEN-1:0]           ialu_main_op2_i,
   output logic                           ialu_rvm_res_rdy_o,
   output logic [SCR1_XLEN-1:0]           ialu_main_res_o,
   output logic                           busy_o
);

   localparam int unsigned XLEN  = SCR1_XLEN;
   localparam int unsigned PW    = 2 * XLEN;
   localparam int unsigned CNT_W = $clog2(XLEN);

   state_e            state_q, state_d;
   cmd_t              cmd_q;
   logic              neg_q;
   logic              fast_q;
   logic [XLEN-1:0]   fast_res_q;
   logic              rdy_q, busy_q;

   cmd_t              cmd_in_c;
   logic              sgn1_c, sgn2_c, neg_c, fast_c, supported_c;
   logic [XLEN-1:0]   op1m_c, op2m_c, fast_res_c, calc_res_c;
   logic              latch_c, load_c, step_c;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     prod_c;
   logic [XLEN-1:0]   quo_c, rem_c;
   logic [CNT_W-1:0]  cnt;

   // Decode of the incoming command: magnitudes, result sign, fast path.
   always_comb begin
      cmd_in_c    = CMD_W'(ialu_cmd_i);
      sgn1_c      = is_signed_op1(cmd_in_c) & ialu_main_op1_i[XLEN-1];
      sgn2_c      = is_signed_op2(cmd_in_c) & ialu_main_op2_i[XLEN-1];
      op1m_c      = sgn1_c ? (XLEN'(0) - ialu_main_op1_i) : ialu_main_op1_i;
      op2m_c      = sgn2_c ? (XLEN'(0) - ialu_main_op2_i) : ialu_main_op2_i;
      neg_c       = is_rem(cmd_in_c) ? sgn1_c : (sgn1_c ^ sgn2_c);
      supported_c = is_mul(cmd_in_c) | is_div(cmd_in_c);
      fast_c      = !supported_c || (is_div(cmd_in_c) && (ialu_main_op2_i == '0));
      if (!supported_c) begin
         fast_res_c = '0;
      end else if (is_rem(cmd_in_c)) begin
         fast_res_c = ialu_main_op1_i;
      end else begin
         fast_res_c = '1;
      end
   end

   // FSM next-state and datapath controls.
   always_comb begin
      state_d = state_q;
      latch_c = 1'b0;
      load_c  = 1'b0;
      step_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ialu_rvm_cmd_vd_i) begin
               latch_c = 1'b1;
               if (fast_c) begin
                  state_d = ST_DONE;
               end else begin
                  load_c  = 1'b1;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (!ialu_rvm_cmd_vd_i) begin
               state_d = ST_IDLE;
            end else begin
               step_c = 1'b1;
               if (cnt == '0) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         neg_q      <= 1'b0;
         fast_q     <= 1'b0;
         fast_res_q <= '0;
         rdy_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d == ST_DONE);
         busy_q  <= (state_d != ST_IDLE);
         if (latch_c) begin
            cmd_q      <= cmd_in_c;
            neg_q      <= neg_c;
            fast_q     <= fast_c;
            fast_res_q <= fast_res_c;
         end
      end
   end

   ialu_rvm_muldiv_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load_c),
      .step_i  (step_c),
      .mul_i   (is_mul(cmd_q)),
      .op1_i   (op1m_c),
      .op2_i   (op2m_c),
      .acc_o   (acc),
      .cnt_o   (cnt)
   );

   // Sign fix-up and result selection on the finished magnitudes.
   always_comb begin
      prod_c     = neg_q ? (PW'(0) - acc) : acc;
      quo_c      = neg_q ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
      rem_c      = neg_q ? (XLEN'(0) - acc[PW-1:XLEN]) : acc[PW-1:XLEN];
      calc_res_c = '0;
      case (cmd_q)
         CMD_MUL:                          calc_res_c = prod_c[XLEN-1:0];
         CMD_MULH, CMD_MULHSU, CMD_MULHU:  calc_res_c = prod_c[PW-1:XLEN];
         CMD_DIV, CMD_DIVU:                calc_res_c = quo_c;
         CMD_REM, CMD_REMU:                calc_res_c = rem_c;
         default:                          calc_res_c = '0;
      endcase
   end

   assign ialu_rvm_res_rdy_o = rdy_q;
   assign busy_o             = busy_q;
   assign ialu_main_res_o    = rdy_q ? (fast_q ? fast_res_q : calc_res_c) : '0;

endmodule

// File: doc/ialu_rvm_muldiv.md
Name: ialu_rvm_muldiv

Overview:
- Responder side of the IALU RVM handshake.
- Accepts a multiply/divide command on ialu_rvm_cmd_vd_i with ialu_main_op1_i, ialu_main_op2_i and ialu_cmd_i.
- Computes the result iteratively, one bit per cycle, and signals completion with a one-cycle ialu_rvm_res_rdy_o pulse carrying ialu_main_res_o.
- Sits beside the single-cycle IALU datapath; the pipeline initiator holds the command until the result is ready.

Parameters:
- SCR1_XLEN, 8, operand/result width; must be even and >= 4.
- SCR1_IALU_CMD_WIDTH, 8, width of ialu_cmd_i.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- ialu_rvm_cmd_vd_i  input  1  command valid, level; held high by the initiator until res_rdy is seen.
- ialu_cmd_i  input  SCR1_IALU_CMD_WIDTH  operation code (package encoding).
- ialu_main_op1_i  input  SCR1_XLEN  multiplicand / dividend.
- ialu_main_op2_i  input  SCR1_XLEN  multiplier / divisor.
- ialu_rvm_res_rdy_o  output  1  one-cycle pulse: result valid.
- ialu_main_res_o  output  SCR1_XLEN  result; valid only while res_rdy=1, otherwise 0.
- busy_o  output  1  high in CALC and DONE.

Behaviour:
- Reset: state IDLE; all registers 0; ialu_rvm_res_rdy_o=0, ialu_main_res_o=0, busy_o=0. Reset mid-operation aborts with no res_rdy.
- States: IDLE, CALC, DONE.
- IDLE:
  - On clk with cmd_vd=1: latch cmd and operands (cycle 0).
  - Supported cmd with no fast path -> CALC, counter=SCR1_XLEN-1.
  - Otherwise -> DONE directly.
- Fast paths (res_rdy at cycle 1):
  - DIV/DIVU with op2=0: quotient all-ones.
  - REM/REMU with op2=0: remainder = op1.
  - Unsupported cmd: result 0.
- CALC:
  - One iteration per cycle on unsigned magnitudes.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - counter decrements; at counter==0 -> DONE.
- Sign handling:
  - Operand magnitudes are taken at latch.
  - Signed: MUL/MULH both operands; MULHSU op1 only; DIV/REM both operands.
  - Final negation is combinational in DONE.
  - Product sign = XOR of the signed operand signs.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
- Overflow: DIV of the most-negative value by -1 gives quotient = op1, REM gives 0. This falls out of the magnitude algorithm; no special path needed.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- DONE: res_rdy=1 for exactly one cycle, then -> IDLE. Iterative latency = SCR1_XLEN+1 cycles from the accepting edge to the res_rdy cycle.
- Back-to-back: if cmd_vd is still high in the cycle after the DONE pulse, a new command is latched from that cycle. No bubble beyond the IDLE cycle.
- Abort: cmd_vd sampled 0 while in CALC -> IDLE next cycle, no res_rdy. In DONE the pulse is still emitted.
- Operand or cmd changes while busy are ignored; only latched values are used.

Decomposition:
- Package ialu_rvm_pkg:
  - cmd encodings MUL=1, MULH=2, MULHSU=3, MULHU=4, DIV=5, DIVU=6, REM=7, REMU=8 (SCR1_IALU_CMD_WIDTH wide).
  - state enum.
  - helper functions is_mul/is_div/is_signed_op1/is_signed_op2.
- One sub-module: ialu_rvm_muldiv_iter — the shared iteration datapath (product/remainder shift register, adder/subtractor, counter). The top holds the FSM, sign fix-up and result mux.

Test Plan:
- MUL/MULHU, op1=0xFF, op2=0xFF (XLEN=8) -> MUL res 0x01, MULHU res 0xFE; res_rdy exactly 9 cycles after accept, one cycle wide.
- MULH 0x80*0xFF -> 0x00; MULHSU 0xFF*0xFF -> 0xFF; MUL 0x03*0x05 -> 0x0F.
- DIV 0xF9/0x02 -> 0xFD; REM -> 0xFF; DIV 0x80/0xFF -> 0x80; REM 0x80/0xFF -> 0x00.
- DIVU 0x23/0x00 -> 0xFF with res_rdy at cycle 1; REMU 0x23/0x00 -> 0x23; unsupported cmd 0x00 -> res 0 at cycle 1.
- Abort: MUL accepted, cmd_vd dropped at cycle 4 -> no res_rdy, busy_o=0 next cycle; then MUL 0x03*0x05 -> 0x0F with normal latency.
- Back-to-back DIVU 0x64/0x0A -> 0x0A, then REMU 0x64/0x07 -> 0x02 with cmd_vd held high. Separately, rst_n_i asserted in CALC -> all outputs 0 immediately, no stale pulse after release.
